// File: rtl/mem_access_unit_pkg.sv
// mem_access_unit_pkg: shared types for the load/store unit
package mem_access_unit_pkg;
  typedef enum logic [1:0] {MEM_B, MEM_H, MEM_W, MEM_D} mem_size_t;
  typedef struct packed {
    logic      is_store;
    logic      is_unsigned;
    mem_size_t size;
  } mem_op_t;
  typedef enum logic [1:0] {
    EXC_NONE         = 2'd0,
    EXC_MISALIGN     = 2'd1,
    EXC_ILLEGAL_SIZE = 2'd2
  } mem_exc_t;
  typedef enum logic [2:0] {IDLE, REQ0, WAIT0, REQ1, WAIT1, RESP} mem_state_t;
endpackage

// File: rtl/mem_access_unit_if.sv
// mem_access_unit_if: core request/response and data-memory bus bundle
interface mem_access_unit_if #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32
);
  import mem_access_unit_pkg::*;
  localparam int BYTES = XLEN / 8;
  logic              req_valid;
  logic              req_ready;
  mem_op_t           req_op;
  logic [ADDR_W-1:0] req_addr;
  logic [XLEN-1:0]   req_wdata;
  logic              resp_valid;
  logic [XLEN-1:0]   resp_rdata;
  logic              resp_exc;
  mem_exc_t          resp_cause;
  logic              mem_valid;
  logic              mem_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [BYTES-1:0]  mem_be;
  logic [XLEN-1:0]   mem_wdata;
  logic              mem_rvalid;
  logic [XLEN-1:0]   mem_rdata;
  modport slave (
    input  req_valid, req_op, req_addr, req_wdata, mem_ready, mem_rvalid, mem_rdata,
    output req_ready, resp_valid, resp_rdata, resp_exc, resp_cause,
           mem_valid, mem_we, mem_addr, mem_be, mem_wdata
  );
  modport master (
    output req_valid, req_op, req_addr, req_wdata, mem_ready, mem_rvalid, mem_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_exc, resp_cause,
           mem_valid, mem_we, mem_addr, mem_be, mem_wdata
  );
endinterface

// File: rtl/mem_access_unit_lane_align.sv
// mem_lane_align: byte-lane mask, store shift and load extract/extend over a two-word window
module mem_lane_align
  import mem_access_unit_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  mem_size_t                    size,
  input  logic                         is_unsigned,
  input  logic [$clog2(XLEN/8)-1:0]    off,
  input  logic [XLEN-1:0]              wdata,
  input  logic [XLEN-1:0]              hi,
  input  logic [XLEN-1:0]              lo,
  output logic [2*(XLEN/8)-1:0]        be,
  output logic [2*XLEN-1:0]            wdata_sh,
  output logic [XLEN-1:0]              rdata
);
  localparam int BYTES = XLEN / 8;
  logic [3:0]      nb;
  logic [XLEN-1:0] raw, m, top;
  // m keeps the low n bytes; a shift by >= XLEN yields all ones for full-width accesses
  always_comb begin
    nb       = 4'd1 << size;
    be       = ~({2*BYTES{1'b1}} << nb) << off;
    wdata_sh = {{XLEN{1'b0}}, wdata} << {off, 3'b000};
    raw      = XLEN'({hi, lo} >> {off, 3'b000});
    m        = ~({XLEN{1'b1}} << {nb, 3'b000});
    top      = m & ~(m >> 1);
    rdata    = (raw & m) | ((!is_unsigned && |(raw & top)) ? ~m : '0);
  end
endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: one-at-a-time load/store unit onto a handshaked data-memory port.
// Define MEM_MISALIGN_SPLIT_EN to service misaligned accesses (two beats when crossing a word).
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32
) (
  input logic              clk,
  input logic              rst_n,
  mem_access_unit_if.slave bus
);
  localparam int BYTES = XLEN / 8;
  localparam int OFF_W = $clog2(BYTES);
`ifdef MEM_MISALIGN_SPLIT_EN
  localparam bit SPLIT_EN = 1'b1;
`else
  localparam bit SPLIT_EN = 1'b0;
`endif
  mem_state_t        state;
  mem_op_t           op_q;
  logic [OFF_W-1:0]  off_q, off_c;
  logic [XLEN-1:0]   wdata_q, wdata_c, lo_q, hi, lo, ld_data;
  logic              split_q, split_c, illegal, misalign, mis_exc, uns_c;
  mem_size_t         size_c;
  logic [2*BYTES-1:0] be_full;
  logic [2*XLEN-1:0]  wd_full;
  // In IDLE the lane logic looks at the incoming request so beat 0 can be registered on accept
  always_comb begin
    size_c   = state == IDLE ? bus.req_op.size : op_q.size;
    uns_c    = state == IDLE ? bus.req_op.is_unsigned : op_q.is_unsigned;
    off_c    = state == IDLE ? bus.req_addr[OFF_W-1:0] : off_q;
    wdata_c  = state == IDLE ? bus.req_wdata : wdata_q;
    lo       = state == WAIT0 ? bus.mem_rdata : lo_q;
    hi       = state == WAIT1 ? bus.mem_rdata : '0;
    illegal  = XLEN == 32 && bus.req_op.size == MEM_D;
    misalign = (bus.req_op.size == MEM_H && bus.req_addr[0]) ||
               (bus.req_op.size == MEM_W && |bus.req_addr[1:0]) ||
               (bus.req_op.size == MEM_D && |bus.req_addr[2:0]);
    mis_exc  = misalign && !SPLIT_EN;
    split_c  = |be_full[2*BYTES-1:BYTES];
  end
  mem_lane_align #(.XLEN(XLEN)) u_align (
    .size(size_c), .is_unsigned(uns_c), .off(off_c), .wdata(wdata_c),
    .hi(hi), .lo(lo), .be(be_full), .wdata_sh(wd_full), .rdata(ld_data)
  );
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state           <= IDLE;
      bus.req_ready   <= 1'b1;
      bus.resp_valid  <= 1'b0;
      bus.resp_exc    <= 1'b0;
      bus.resp_cause  <= EXC_NONE;
      bus.resp_rdata  <= '0;
      bus.mem_valid   <= 1'b0;
      bus.mem_we      <= 1'b0;
      bus.mem_addr    <= '0;
      bus.mem_be      <= '0;
      bus.mem_wdata   <= '0;
      op_q            <= '0;
      off_q           <= '0;
      wdata_q         <= '0;
      lo_q            <= '0;
      split_q         <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.req_valid) begin
          op_q          <= bus.req_op;
          off_q         <= bus.req_addr[OFF_W-1:0];
          wdata_q       <= bus.req_wdata;
          split_q       <= split_c;
          bus.req_ready <= 1'b0;
          if (illegal || mis_exc) begin
            state          <= RESP;
            bus.resp_valid <= 1'b1;
            bus.resp_exc   <= 1'b1;
            bus.resp_cause <= illegal ? EXC_ILLEGAL_SIZE : EXC_MISALIGN;
          end else begin
            state         <= REQ0;
            bus.mem_valid <= 1'b1;
            bus.mem_we    <= bus.req_op.is_store;
            bus.mem_addr  <= {bus.req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
            bus.mem_be    <= be_full[BYTES-1:0];
            bus.mem_wdata <= wd_full[XLEN-1:0];
          end
        end
        REQ0: if (bus.mem_ready) begin
          bus.mem_valid <= 1'b0;
          if (!op_q.is_store) state <= WAIT0;
          else if (split_q) begin
            state         <= REQ1;
            bus.mem_valid <= 1'b1;
            bus.mem_addr  <= bus.mem_addr + ADDR_W'(BYTES);
            bus.mem_be    <= be_full[2*BYTES-1:BYTES];
            bus.mem_wdata <= wd_full[2*XLEN-1:XLEN];
          end else begin
            state          <= RESP;
            bus.resp_valid <= 1'b1;
          end
        end
        WAIT0: if (bus.mem_rvalid) begin
          lo_q <= bus.mem_rdata;
          if (split_q) begin
            state         <= REQ1;
            bus.mem_valid <= 1'b1;
            bus.mem_addr  <= bus.mem_addr + ADDR_W'(BYTES);
            bus.mem_be    <= be_full[2*BYTES-1:BYTES];
          end else begin
            state          <= RESP;
            bus.resp_valid <= 1'b1;
            bus.resp_rdata <= ld_data;
          end
        end
        REQ1: if (bus.mem_ready) begin
          bus.mem_valid <= 1'b0;
          state         <= op_q.is_store ? RESP : WAIT1;
          bus.resp_valid <= op_q.is_store;
        end
        WAIT1: if (bus.mem_rvalid) begin
          state          <= RESP;
          bus.resp_valid <= 1'b1;
          bus.resp_rdata <= ld_data;
        end
        RESP: begin
          state          <= IDLE;
          bus.req_ready  <= 1'b1;
          bus.resp_valid <= 1'b0;
          bus.resp_exc   <= 1'b0;
          bus.resp_cause <= EXC_NONE;
          bus.resp_rdata <= '0;
          bus.mem_we     <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed vectors against a stalling memory responder
module tb_mem_access_unit;
  import mem_access_unit_pkg::*;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  mem_access_unit_if #(.XLEN(32), .ADDR_W(32)) bus ();
  mem_access_unit_if #(.XLEN(64), .ADDR_W(32)) bus64 ();
  mem_access_unit #(.XLEN(32), .ADDR_W(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  mem_access_unit #(.XLEN(64), .ADDR_W(32)) dut64 (.clk(clk), .rst_n(rst_n), .bus(bus64));
  int n_run = 0;
  int n_fail = 0;
  int stall = 0;
  int rv_delay = 0;
  int beats = 0;
  logic hs_done = 1'b0;
  logic [31:0] b_addr [2];
  logic [3:0]  b_be   [2];
  logic [31:0] b_wd   [2];
  logic        b_we   [2];
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask
  function automatic logic [31:0] word(input logic [31:0] a);
    case (a)
      32'h1000: word = 32'h80FF_1234;
      32'h3000: word = 32'h4433_2211;
      32'h3004: word = 32'h8877_6655;
      default:  word = 32'h0;
    endcase
  endfunction
  // memory responder: records each beat, stalls mem_ready, returns load data
  initial begin
    int k;
    bus.mem_ready = 1'b0; bus.mem_rvalid = 1'b0; bus.mem_rdata = '0;
    @(negedge clk);
    forever begin
      if (bus.mem_valid === 1'b1 && rst_n) begin
        k = beats % 2;
        b_addr[k] = bus.mem_addr; b_be[k] = bus.mem_be; b_wd[k] = bus.mem_wdata; b_we[k] = bus.mem_we;
        beats++;
        repeat (stall) begin
          @(negedge clk);
          check("hold_valid", bus.mem_valid, 1);
          check("hold_addr", bus.mem_addr, b_addr[k]);
          check("hold_be", bus.mem_be, b_be[k]);
          check("hold_wdata", bus.mem_wdata, b_wd[k]);
        end
        bus.mem_ready = 1'b1;
        @(negedge clk);
        bus.mem_ready = 1'b0;
        hs_done = 1'b1;
        if (!b_we[k]) begin
          repeat (rv_delay) @(negedge clk);
          bus.mem_rvalid = 1'b1; bus.mem_rdata = word(b_addr[k]);
          @(negedge clk);
          bus.mem_rvalid = 1'b0;
        end
      end else @(negedge clk);
    end
  end
  task automatic do_req(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                        output logic [31:0] rd, output logic exc, output logic [1:0] cause, output int lat);
    beats = 0; hs_done = 1'b0; lat = 2;
    @(negedge clk);
    check("ready_idle", bus.req_ready, 1);
    bus.req_valid = 1'b1; bus.req_op = op; bus.req_addr = addr; bus.req_wdata = wdata;
    @(negedge clk);
    bus.req_valid = 1'b0;
    while (bus.resp_valid !== 1'b1 && lat < 40) begin
      check("ready_busy", bus.req_ready, 0);
      lat++;
      @(negedge clk);
    end
    check("resp_seen", bus.resp_valid, 1);
    check("ready_in_resp", bus.req_ready, 0);
    rd = bus.resp_rdata; exc = bus.resp_exc; cause = bus.resp_cause;
    @(negedge clk);
    check("resp_pulse", bus.resp_valid, 0);
    check("ready_after", bus.req_ready, 1);
  endtask
  logic [3:0]  op64  [2] = '{4'b0011, 4'b0010};
  logic [31:0] ad64  [2] = '{32'h0, 32'h4};
  logic [63:0] rw64  [2] = '{64'h8000_0000_0000_0001, 64'h8765_4321_0000_0000};
  logic [7:0]  be64  [2] = '{8'hFF, 8'hF0};
  logic [63:0] ex64  [2] = '{64'h8000_0000_0000_0001, 64'hFFFF_FFFF_8765_4321};
  initial begin
    logic [31:0] rd;
    logic exc, saw, rdy;
    logic [1:0] cause;
    int lat;
    bus.req_valid = 1'b0; bus.req_op = '0; bus.req_addr = '0; bus.req_wdata = '0;
    bus64.req_valid = 1'b0; bus64.req_op = '0; bus64.req_addr = '0; bus64.req_wdata = '0;
    bus64.mem_ready = 1'b0; bus64.mem_rvalid = 1'b0; bus64.mem_rdata = '0;
    repeat (2) @(negedge clk);
    check("rst_req_ready", bus.req_ready, 1);
    check("rst_resp_valid", bus.resp_valid, 0);
    check("rst_resp_exc", bus.resp_exc, 0);
    check("rst_resp_cause", bus.resp_cause, 0);
    check("rst_resp_rdata", bus.resp_rdata, 0);
    check("rst_mem_valid", bus.mem_valid, 0);
    check("rst_mem_we", bus.mem_we, 0);
    check("rst_mem_addr", bus.mem_addr, 0);
    check("rst_mem_be", bus.mem_be, 0);
    check("rst_mem_wdata", bus.mem_wdata, 0);
    rst_n = 1'b1;
    stall = 0;
    do_req(4'b0000, 32'h1003, 32'h0, rd, exc, cause, lat);
    check("lb_rdata", rd, 32'hFFFF_FF80); check("lb_exc", exc, 0); check("lb_lat", lat, 4);
    check("lb_beats", beats, 1); check("lb_addr", b_addr[0], 32'h1000); check("lb_be", b_be[0], 4'b1000);
    check("lb_we", b_we[0], 0);
    stall = 3;
    do_req(4'b0100, 32'h1003, 32'h0, rd, exc, cause, lat);
    check("lbu_rdata", rd, 32'h0000_0080); check("lbu_addr", b_addr[0], 32'h1000);
    stall = 0;
    do_req(4'b1001, 32'h2002, 32'h1234_BEEF, rd, exc, cause, lat);
    check("sh_be", b_be[0], 4'b1100); check("sh_wdata", b_wd[0], 32'hBEEF_0000); check("sh_we", b_we[0], 1);
    check("sh_addr", b_addr[0], 32'h2000); check("sh_lat", lat, 3); check("sh_rdata", rd, 0); check("sh_exc", exc, 0);
    stall = 3;
    do_req(4'b1010, 32'h2004, 32'hCAFE_F00D, rd, exc, cause, lat);
    check("sw_be", b_be[0], 4'b1111); check("sw_wdata", b_wd[0], 32'hCAFE_F00D); check("sw_addr", b_addr[0], 32'h2004);
    do_req(4'b0001, 32'h1002, 32'h0, rd, exc, cause, lat);
    check("lh_rdata", rd, 32'hFFFF_80FF); check("lh_be", b_be[0], 4'b1100);
    do_req(4'b0101, 32'h1000, 32'h0, rd, exc, cause, lat);
    check("lhu_rdata", rd, 32'h0000_1234); check("lhu_be", b_be[0], 4'b0011);
    do_req(4'b0011, 32'h0, 32'h0, rd, exc, cause, lat);
    check("ld32_exc", exc, 1); check("ld32_cause", cause, EXC_ILLEGAL_SIZE); check("ld32_beats", beats, 0);
    check("ld32_rdata", rd, 0);
`ifdef MEM_MISALIGN_SPLIT_EN
    stall = 0;
    do_req(4'b0010, 32'h3001, 32'h0, rd, exc, cause, lat);
    check("lwx_rdata", rd, 32'h5544_3322); check("lwx_exc", exc, 0); check("lwx_beats", beats, 2);
    check("lwx_addr0", b_addr[0], 32'h3000); check("lwx_be0", b_be[0], 4'b1110);
    check("lwx_addr1", b_addr[1], 32'h3004); check("lwx_be1", b_be[1], 4'b0001); check("lwx_lat", lat, 6);
    stall = 3;
    do_req(4'b0001, 32'h1001, 32'h0, rd, exc, cause, lat);
    check("lhm_rdata", rd, 32'hFFFF_FF12); check("lhm_be", b_be[0], 4'b0110); check("lhm_beats", beats, 1);
    do_req(4'b1010, 32'h2006, 32'hAABB_CCDD, rd, exc, cause, lat);
    check("swx_beats", beats, 2); check("swx_addr0", b_addr[0], 32'h2004); check("swx_addr1", b_addr[1], 32'h2008);
    check("swx_be0", b_be[0], 4'b1100); check("swx_wd0", b_wd[0], 32'hCCDD_0000);
    check("swx_be1", b_be[1], 4'b0011); check("swx_wd1", b_wd[1], 32'h0000_AABB); check("swx_exc", exc, 0);
`else
    do_req(4'b0010, 32'h3001, 32'h0, rd, exc, cause, lat);
    check("lwx_exc", exc, 1); check("lwx_cause", cause, EXC_MISALIGN); check("lwx_beats", beats, 0);
    do_req(4'b0001, 32'h1001, 32'h0, rd, exc, cause, lat);
    check("lhm_exc", exc, 1); check("lhm_cause", cause, EXC_MISALIGN); check("lhm_beats", beats, 0);
`endif
    stall = 0; rv_delay = 4; beats = 0; hs_done = 1'b0;
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_op = 4'b0010; bus.req_addr = 32'h1000;
    @(negedge clk);
    bus.req_valid = 1'b0;
    for (int i = 0; i < 20 && !hs_done; i++) @(negedge clk);
    check("rst_hs", hs_done, 1);
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    check("rstw_ready", bus.req_ready, 1);
    saw = 1'b0; rdy = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      saw = saw | bus.resp_valid | bus.mem_valid;
      rdy = rdy & bus.req_ready;
    end
    check("rstw_quiet", saw, 0); check("rstw_ready_hold", rdy, 1);
    rv_delay = 0;
    do_req(4'b0010, 32'h3000, 32'h0, rd, exc, cause, lat);
    check("lw_after_rst", rd, 32'h4433_2211); check("lw_after_exc", exc, 0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      bus64.req_valid = 1'b1; bus64.req_op = op64[i]; bus64.req_addr = ad64[i];
      @(negedge clk);
      bus64.req_valid = 1'b0;
      check("d64_valid", bus64.mem_valid, 1); check("d64_be", bus64.mem_be, be64[i]);
      check("d64_addr", bus64.mem_addr, 0); check("d64_we", bus64.mem_we, 0);
      bus64.mem_ready = 1'b1;
      @(negedge clk);
      bus64.mem_ready = 1'b0; bus64.mem_rvalid = 1'b1; bus64.mem_rdata = rw64[i];
      @(negedge clk);
      bus64.mem_rvalid = 1'b0;
      check("d64_resp", bus64.resp_valid, 1); check("d64_rdata", bus64.resp_rdata, ex64[i]);
      check("d64_exc", bus64.resp_exc, 0);
      @(negedge clk);
    end
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d tests run", n_run);
    $fatal(1);
  end
endmodule
